add_order: RTL and testbench

ADD_ORDER -- requirements
Module: add_order

---
 rtl/add_order.sv | 95 +++++++++
 tb/tb_add_order.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/add_order.sv
// add_order: inserts an order word into the first empty slot of the buy or sell book
module add_order #(
    parameter int MAX_BOOK_SIZE = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        side,
    input  logic [15:0] order_id,
    input  logic [15:0] order_qty,
    input  logic [15:0] order_price,
    input  logic [47:0] buy_rdata,
    input  logic [47:0] sell_rdata,
    output logic [11:0] ram_addr,
    output logic [47:0] ram_wdata,
    output logic        buy_wren,
    output logic        sell_wren,
    output logic [11:0] slot,
    output logic        full,
    output logic        done
);
    typedef enum logic [2:0] {IDLE, READ, CHECK, WRITE, DONE} state_t;

    state_t      state;
    state_t      next;
    logic [11:0] i;
    logic [11:0] i_next;
    logic        side_q;
    logic [47:0] word_q;
    logic [47:0] rdata;
    logic        last;

    assign rdata = side_q ? sell_rdata : buy_rdata;
    assign last  = i == 12'(MAX_BOOK_SIZE - 1);

    // Next-state and scan index: walk slots until an empty one or the end of the book
    always_comb begin
        next   = state;
        i_next = i;
        case (state)
            IDLE: begin
                if (start) begin
                    next   = (order_qty == 16'd0) ? DONE : READ;
                    i_next = 12'd0;
                end
            end
            READ:  next = CHECK;
            CHECK: begin
                if (rdata == 48'd0) begin
                    next = WRITE;
                end else if (!last) begin
                    next   = READ;
                    i_next = i + 12'd1;
                end else begin
                    next = DONE;
                end
            end
            WRITE: next = DONE;
            DONE:  next = start ? DONE : IDLE;
            default: next = IDLE;
        endcase
    end

    // State, latched request and registered RAM/result outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            i         <= 12'd0;
            side_q    <= 1'b0;
            word_q    <= 48'd0;
            ram_addr  <= 12'd0;
            ram_wdata <= 48'd0;
            buy_wren  <= 1'b0;
            sell_wren <= 1'b0;
            slot      <= 12'd0;
            full      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= next;
            i         <= i_next;
            buy_wren  <= next == WRITE && !side_q;
            sell_wren <= next == WRITE && side_q;
            done      <= next == DONE;
            if (state == IDLE && start) full <= order_qty == 16'd0;
            if (state == IDLE && start && order_qty != 16'd0) begin
                side_q <= side;
                word_q <= {order_id, order_qty, order_price};
            end
            if (next == READ) ram_addr <= i_next;
            if (next == WRITE) ram_wdata <= word_q;
            if (state == CHECK && next == DONE) full <= 1'b1;
            if (state == WRITE) slot <= i;
        end
    end
endmodule

// File: tb/tb_add_order.sv
// tb_add_order: directed checks of add_order against a small two-book RAM model
module tb_add_order;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        side = 1'b0;
    logic [15:0] order_id = 16'd0;
    logic [15:0] order_qty = 16'd0;
    logic [15:0] order_price = 16'd0;
    logic [47:0] buy_rdata;
    logic [47:0] sell_rdata;
    logic [11:0] ram_addr;
    logic [47:0] ram_wdata;
    logic        buy_wren;
    logic        sell_wren;
    logic [11:0] slot;
    logic        full;
    logic        done;

    logic [47:0] buy_mem [10];
    logic [47:0] sell_mem [10];
    int tests = 0;
    int failed = 0;
    int edges;
    int wr_edge;
    int buy_cyc = 0;
    int sell_cyc = 0;
    int bad_writes = 0;
    logic [11:0] wr_addr;

    add_order dut (
        .clk(clk), .rst(rst), .start(start), .side(side),
        .order_id(order_id), .order_qty(order_qty), .order_price(order_price),
        .buy_rdata(buy_rdata), .sell_rdata(sell_rdata),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .buy_wren(buy_wren), .sell_wren(sell_wren),
        .slot(slot), .full(full), .done(done)
    );

    assign buy_rdata  = ram_addr < 12'd10 ? buy_mem[ram_addr[3:0]] : 48'd0;
    assign sell_rdata = ram_addr < 12'd10 ? sell_mem[ram_addr[3:0]] : 48'd0;

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock edge; the RAM model commits any write seen in the cycle just entered
    task automatic tick;
        @(posedge clk);
        #1;
        if (buy_wren || sell_wren) begin
            wr_addr = ram_addr;
            if (ram_addr >= 12'd10 || (buy_wren && sell_wren)) bad_writes++;
            else if (buy_wren) begin
                if (buy_mem[ram_addr[3:0]] != 48'd0) bad_writes++;
                buy_mem[ram_addr[3:0]] = ram_wdata;
            end else begin
                if (sell_mem[ram_addr[3:0]] != 48'd0) bad_writes++;
                sell_mem[ram_addr[3:0]] = ram_wdata;
            end
        end
        if (buy_wren) buy_cyc++;
        if (sell_wren) sell_cyc++;
    endtask

    // Accept edge is edge 0; edges ends as the edge after which done was seen
    task automatic go(input logic s, input logic [15:0] id, input logic [15:0] q, input logic [15:0] p);
        int c;
        side = s; order_id = id; order_qty = q; order_price = p; start = 1'b1;
        tick;
        side = ~s; order_id = ~id; order_qty = 16'd0; order_price = ~p;
        edges = 0;
        wr_edge = -1;
        while (!done && edges < 100) begin
            c = buy_cyc + sell_cyc;
            tick;
            edges++;
            if (buy_cyc + sell_cyc != c) wr_edge = edges;
        end
    endtask

    task automatic release_start(input string tag);
        start = 1'b0;
        tick;
        chk(tag, done, 1'b0);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_done"}, done, 1'b0);
        chk({tag, "_full"}, full, 1'b0);
        chk({tag, "_slot"}, slot, 12'd0);
        chk({tag, "_addr"}, ram_addr, 12'd0);
        chk({tag, "_wdata"}, ram_wdata, 48'd0);
        chk({tag, "_wren"}, {buy_wren, sell_wren}, 2'b00);
    endtask

    initial begin
        for (int k = 0; k < 10; k++) begin
            buy_mem[k] = 48'd0;
            sell_mem[k] = 48'd0;
        end
        #1 rst = 1'b1;
        #1 chk_zero("reset");
        #20 rst = 1'b0;

        // Empty buy book, first insert lands in slot 0
        go(1'b0, 16'd1, 16'd5, 16'd100);
        chk("t1_edges", edges, 3);
        chk("t1_wr_edge", wr_edge, 2);
        chk("t1_wr_addr", wr_addr, 12'd0);
        chk("t1_mem", buy_mem[0], 48'h0001_0005_0064);
        chk("t1_slot", slot, 12'd0);
        chk("t1_full", full, 1'b0);
        chk("t1_cyc", {buy_cyc[7:0], sell_cyc[7:0]}, 16'h0100);
        release_start("t1_done_clear");

        // Sell book with slots 0..2 occupied
        sell_mem[0] = 48'h1; sell_mem[1] = 48'h2; sell_mem[2] = 48'h3;
        go(1'b1, 16'd2, 16'd7, 16'd50);
        chk("t2_edges", edges, 9);
        chk("t2_wr_edge", wr_edge, 8);
        chk("t2_wr_addr", wr_addr, 12'd3);
        chk("t2_mem", sell_mem[3], 48'h0002_0007_0032);
        chk("t2_slot", slot, 12'd3);
        chk("t2_full", full, 1'b0);
        chk("t2_cyc", {buy_cyc[7:0], sell_cyc[7:0]}, 16'h0101);
        release_start("t2_done_clear");

        // Reset during the check of slot 2 of the buy book
        buy_mem[1] = 48'h5;
        side = 1'b0; order_id = 16'd3; order_qty = 16'd9; order_price = 16'd77; start = 1'b1;
        repeat (6) tick;
        rst = 1'b1;
        #1 chk_zero("t5_rst");
        chk("t5_mem", buy_mem[2], 48'd0);
        start = 1'b0;
        @(negedge clk) rst = 1'b0;
        tick;
        chk("t5_idle", done, 1'b0);
        go(1'b0, 16'd3, 16'd9, 16'd77);
        chk("t5_edges", edges, 7);
        chk("t5_slot", slot, 12'd2);
        chk("t5_mem", buy_mem[2], 48'h0003_0009_004D);
        chk("t5_cyc", {buy_cyc[7:0], sell_cyc[7:0]}, 16'h0201);

        // start held past done must not retrigger
        for (int k = 0; k < 5; k++) begin
            tick;
            chk("hold_done", done, 1'b1);
        end
        chk("hold_cyc", {buy_cyc[7:0], sell_cyc[7:0]}, 16'h0201);
        release_start("hold_done_clear");

        // Completely full buy book
        for (int k = 3; k < 10; k++) buy_mem[k] = 48'h100 + 48'(k);
        go(1'b0, 16'd4, 16'd1, 16'd1);
        chk("t3_edges", edges, 20);
        chk("t3_full", full, 1'b1);
        chk("t3_wr_edge", wr_edge, -1);
        chk("t3_cyc", {buy_cyc[7:0], sell_cyc[7:0]}, 16'h0201);
        release_start("t3_done_clear");

        // Zero quantity is rejected without touching the RAM
        go(1'b1, 16'd5, 16'd0, 16'd9);
        chk("t4_edges", edges, 0);
        chk("t4_full", full, 1'b1);
        chk("t4_wr_edge", wr_edge, -1);
        chk("t4_cyc", {buy_cyc[7:0], sell_cyc[7:0]}, 16'h0201);
        release_start("t4_done_clear");

        chk("bad_writes", bad_writes, 0);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
